// File: rtl/sys_array_ctrl.sv
// Sequencer for the SysDimension x SysDimension systolic MAC array: feed, flush and drain per tile.
// Optional SYS_CTRL_PERF_EN adds busy-cycle and stall-cycle counters.
//
// state   | meaning
// IDLE    | waiting for start
// FEED    | streaming featureLen words from the buffers into the array edges
// FLUSH   | edges forced to zero while the pipeline drains into the accumulators
// DRAIN   | presenting one result row per handshake
// DONE    | one-cycle completion pulse

module sys_array_ctrl #(
  parameter int SysDimension   = 32,
  parameter int featureLen     = 128,
  parameter int InitialLatency = 45,
  parameter int AddrWidth      = 16,
  parameter int TileWidth      = 8,
  localparam int RowWidth      = (SysDimension > 1) ? $clog2(SysDimension) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [TileWidth-1:0] num_tiles,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 rd_en,
  output logic [AddrWidth-1:0] rd_addr,
  output logic                 feed_zero,
  output logic                 array_enable,
  output logic [RowWidth-1:0]  out_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
`ifdef SYS_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_stalls
`endif
);

  localparam int KWidth    = (featureLen > 1) ? $clog2(featureLen) : 1;
  localparam int FlushLen  = InitialLatency + 2 * (SysDimension - 1);
  localparam int FlushW    = $clog2(InitialLatency + 2 * SysDimension);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [TileWidth-1:0] num_tiles_q;
  logic [TileWidth-1:0] tile_idx;
  logic [KWidth-1:0]    k;
  logic [AddrWidth-1:0] base;
  logic [RowWidth-1:0]  row;
  logic [FlushW-1:0]    flush_cnt;
  logic                 rd_en_q;

  logic                 in_idle;
  logic                 in_feed;
  logic                 in_flush;
  logic                 in_drain;
  logic                 k_last;
  logic                 row_last;
  logic                 handshake;
  logic                 flush_tc;
  logic [TileWidth:0]   tile_next;
  logic                 more_tiles;
  logic                 accept_start;

  assign in_idle   = (state == S_IDLE);
  assign in_feed   = (state == S_FEED);
  assign in_flush  = (state == S_FLUSH);
  assign in_drain  = (state == S_DRAIN);

  assign k_last     = (k == KWidth'(featureLen - 1));
  assign row_last   = (row == RowWidth'(SysDimension - 1));
  assign flush_tc   = (flush_cnt == '0);
  assign tile_next  = {1'b0, tile_idx} + 1'b1;
  assign more_tiles = (tile_next < {1'b0, num_tiles_q});
  assign accept_start = in_idle & start;

  assign busy      = ~in_idle;
  assign done      = (state == S_DONE);
  assign rd_en     = in_feed & in_valid;
  assign rd_addr   = base + AddrWidth'(k);
  assign feed_zero = in_flush;
  // Buffer data arrives one cycle after the strobe, so the array steps on the delayed strobe.
  assign array_enable = (in_feed & rd_en_q) | in_flush;
  assign out_valid = in_drain;
  assign out_row   = row;
  assign handshake = out_valid & out_ready;
  assign out_last  = out_valid & row_last & (tile_idx == (num_tiles_q - TileWidth'(1)));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_tiles == '0) state_nxt = S_DONE;
          else                 state_nxt = S_FEED;
        end
      end
      S_FEED: begin
        if (rd_en && k_last) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (flush_tc) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (handshake && row_last) begin
          if (more_tiles) state_nxt = S_FEED;
          else            state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      rd_en_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_en_q <= rd_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_tiles_q <= '0;
      tile_idx    <= '0;
      k           <= '0;
      base        <= '0;
      row         <= '0;
      flush_cnt   <= '0;
    end else begin
      if (accept_start) begin
        num_tiles_q <= num_tiles;
        tile_idx    <= '0;
        k           <= '0;
        base        <= '0;
        row         <= '0;
      end

      if (rd_en) begin
        if (k_last) begin
          k         <= '0;
          flush_cnt <= FlushW'(FlushLen - 1);
        end else begin
          k <= k + 1'b1;
        end
      end

      if (in_flush && !flush_tc) flush_cnt <= flush_cnt - 1'b1;

      // Address base advances per tile instead of multiplying tile_idx by featureLen.
      if (in_drain && handshake) begin
        if (row_last) begin
          row      <= '0;
          tile_idx <= tile_idx + 1'b1;
          base     <= base + AddrWidth'(featureLen);
        end else begin
          row <= row + 1'b1;
        end
      end
    end
  end

`ifdef SYS_CTRL_PERF_EN
  logic stall_cycle;

  assign stall_cycle = (in_feed & ~in_valid) | (in_drain & ~out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (accept_start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + 32'd1;
      if (stall_cycle) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench for sys_array_ctrl at SysDimension=4, featureLen=8, InitialLatency=5.
// Expected cycle counts are hand-derived per scenario.

module tb_sys_array_ctrl;

  localparam int SD = 4;
  localparam int FL = 8;
  localparam int IL = 5;
  localparam int AW = 16;
  localparam int TW = 8;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic          busy;
  logic          done;
  logic          in_valid = 1'b1;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          feed_zero;
  logic          array_enable;
  logic [RW-1:0] out_row;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
`ifdef SYS_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
  logic [31:0]   perf_stalls;
`endif

  sys_array_ctrl #(
    .SysDimension  (SD),
    .featureLen    (FL),
    .InitialLatency(IL),
    .AddrWidth     (AW),
    .TileWidth     (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_tiles   (num_tiles),
    .busy        (busy),
    .done        (done),
    .in_valid    (in_valid),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .feed_zero   (feed_zero),
    .array_enable(array_enable),
    .out_row     (out_row),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last)
`ifdef SYS_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int r_rd, r_fz, r_ov, r_last, r_last_cyc, r_done_cyc, r_busy, r_en, r_feed_idle;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},    busy, 0);
    chk({tag, "_done"},    done, 0);
    chk({tag, "_rd_en"},   rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_fz"},      feed_zero, 0);
    chk({tag, "_en"},      array_enable, 0);
    chk({tag, "_row"},     out_row, 0);
    chk({tag, "_ov"},      out_valid, 0);
    chk({tag, "_last"},    out_last, 0);
  endtask

  // Cycle 0 drives start; cycle c samples 1 ns after the falling edge of cycle c.
  task automatic run_job(input int ntiles, input int iv_lo_at, input int iv_lo_len,
                         input int or_lo_at, input int or_lo_len,
                         input int start2_at, input int abort_at);
    int  exp_addr = 0;
    int  exp_row  = 0;
    int  exp_tile = 0;
    bit  fin      = 0;
    bit  aborted  = 0;
    r_rd = 0; r_fz = 0; r_ov = 0; r_last = 0; r_busy = 0; r_en = 0; r_feed_idle = 0;
    r_last_cyc = -1; r_done_cyc = -1;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      start     = (c == 0) || (c == start2_at);
      num_tiles = (c == 0) ? TW'(ntiles) : '0;
      in_valid  = !(c >= iv_lo_at && c < iv_lo_at + iv_lo_len);
      out_ready = !(c >= or_lo_at && c < or_lo_at + or_lo_len);
      if (c == abort_at) rst = 1'b0;
      #1;
      if (c == abort_at) begin
        chk_quiet("abort");
        aborted = 1;
        fin = 1;
      end else begin
        if (busy) r_busy++;
        if (rd_en) begin
          chk("rd_addr", rd_addr, exp_addr);
          exp_addr++;
          r_rd++;
        end else if (busy && !in_valid) begin
          chk("rd_addr_hold", rd_addr, exp_addr);
        end
        if (feed_zero) r_fz++;
        if (array_enable) r_en++;
        if (busy && !feed_zero && !out_valid && !done && !array_enable) r_feed_idle++;
        if (out_valid) begin
          r_ov++;
          chk("out_row", out_row, exp_row);
          chk("out_last", out_last, (exp_row == SD - 1 && exp_tile == ntiles - 1));
          if (out_last) begin
            r_last++;
            r_last_cyc = c;
          end
          if (out_ready) begin
            if (exp_row == SD - 1) begin
              exp_row = 0;
              exp_tile++;
            end else begin
              exp_row++;
            end
          end
        end else begin
          chk("out_last_idle", out_last, 0);
        end
        if (done) begin
          r_done_cyc = c;
          fin = 1;
        end
      end
    end
    chk("timeout", fin, 1);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    if (aborted) begin
      @(negedge clk); #1;
      chk("abort_hold_done", done, 0);
      chk("abort_hold_busy", busy, 0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); #1;
        chk("abort_post_done", done, 0);
      end
    end else begin
      @(negedge clk); #1;
      chk("busy_after_done", busy, 0);
      chk("done_single", done, 0);
    end
  endtask

  task automatic chk_single(input string tag);
    chk({tag, "_rd"},      r_rd, 8);
    chk({tag, "_fz"},      r_fz, 11);
    chk({tag, "_ov"},      r_ov, 4);
    chk({tag, "_last"},    r_last, 1);
    chk({tag, "_lastcyc"}, r_last_cyc, 23);
    chk({tag, "_donecyc"}, r_done_cyc, 24);
    chk({tag, "_busy"},    r_busy, 24);
    chk({tag, "_en"},      r_en, 18);
    chk({tag, "_gap"},     r_feed_idle, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_reset_busy", busy, 0);
      chk("post_reset_rd_en", rd_en, 0);
    end

    run_job(1, -1, 0, -1, 0, -1, -1);
    chk_single("single");

    run_job(2, 4, 2, 23, 3, -1, -1);
    chk("two_rd",      r_rd, 16);
    chk("two_fz",      r_fz, 22);
    chk("two_ov",      r_ov, 11);
    chk("two_last",    r_last, 1);
    chk("two_lastcyc", r_last_cyc, 51);
    chk("two_donecyc", r_done_cyc, 52);
    chk("two_busy",    r_busy, 52);
    chk("two_en",      r_en, 36);
    chk("two_gap",     r_feed_idle, 4);
`ifdef SYS_CTRL_PERF_EN
    chk("perf_stalls", perf_stalls, 5);
    chk("perf_cycles", perf_cycles, 52);
    repeat (3) @(negedge clk);
    #1;
    chk("perf_cycles_hold", perf_cycles, 52);
    chk("perf_stalls_hold", perf_stalls, 5);
`endif

    run_job(0, -1, 0, -1, 0, -1, -1);
    chk("zero_donecyc", r_done_cyc, 1);
    chk("zero_rd",      r_rd, 0);
    chk("zero_busy",    r_busy, 1);

    run_job(1, -1, 0, -1, 0, 15, -1);
    chk_single("ign_start");

    run_job(1, -1, 0, -1, 0, -1, 22);
    chk("abort_donecyc", r_done_cyc, -1);
    chk("abort_rows",    r_ov, 2);

    run_job(1, -1, 0, -1, 0, -1, -1);
    chk_single("rerun");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sys_array_ctrl.md
Name: sys_array_ctrl

Overview:
Sequencer for the SysDimension x SysDimension systolic multiply-accumulate array used in the GCN weight-transform stage. Per tile it streams featureLen feature/weight words from the on-chip buffers into the array edges, then flushes the array pipeline. It then drains one result row per handshake to the output buffer. It loops over num_tiles tiles and reports completion.

Parameters:
SysDimension, 32, array rows/columns
featureLen, 128, accumulation length (words fed per tile)
InitialLatency, 45, multiplier+accumulator pipeline depth in cycles
AddrWidth, 16, buffer address width
TileWidth, 8, width of num_tiles

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  launch pulse, sampled only in IDLE
num_tiles  in  TileWidth  tiles to process, latched on start
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at job end
in_valid  in  1  feature and weight buffers both have data for the current address
rd_en  out  1  buffer read strobe
rd_addr  out  AddrWidth  tile_idx*featureLen + k
feed_zero  out  1  array edge inputs forced to 0 (flush)
array_enable  out  1  enable to every array PE
out_row  out  clog2(SysDimension)  result-row select for the output mux
out_valid  out  1  result row presented
out_ready  in  1  output buffer accepts row
out_last  out  1  high with the final row of the final tile

Behaviour:
- Reset (rst=0, any time, including mid-job): state=IDLE; all counters 0; every output 0. The in-flight job is discarded. No done pulse.
- States: IDLE -> FEED -> FLUSH -> DRAIN -> (FEED | DONE) -> IDLE.
- IDLE: start=1 with num_tiles>0 latches num_tiles, clears tile_idx/k, and goes to FEED. start=1 with num_tiles=0 goes to DONE directly (no reads). start in any other state is ignored.
- FEED: rd_en = in_valid. rd_addr = tile_idx*featureLen + k.
  - k increments on each rd_en. When rd_en fires with k=featureLen-1, k clears and state goes to FLUSH.
  - in_valid=0 stalls: rd_en=0, addresses held.
- Buffer read latency is fixed at 1 cycle. array_enable = rd_en delayed 1 cycle in FEED/FLUSH, so the array only advances on real data.
- FLUSH: feed_zero=1 and array_enable=1 for exactly InitialLatency + 2*(SysDimension-1) cycles (flush counter). Then go to DRAIN.
- DRAIN: array_enable=0, feed_zero=0. out_valid=1, out_row = row counter, starting at 0.
  - Row counter advances only on out_valid & out_ready. out_valid stays high while out_ready=0, with out_row stable.
  - After the handshake on row SysDimension-1: tile_idx increments. If tile_idx+1 < num_tiles, go to FEED; otherwise go to DONE.
- out_last = out_valid & (out_row==SysDimension-1) & (tile_idx==num_tiles-1).
- DONE: done=1 for one cycle, busy still 1. Next state is IDLE. busy drops the cycle after done.
- Arithmetic:
  - rd_addr is computed as a running base (base += featureLen per tile), not a multiplier.
  - Widths truncate to AddrWidth; wrap-around is the caller's responsibility.
  - The flush counter is sized clog2(InitialLatency+2*SysDimension).

Optional Feature:
SYS_CTRL_PERF_EN
- Defined: adds outputs perf_cycles (32b) and perf_stalls (32b).
  - Both are cleared on an accepted start.
  - perf_cycles counts every busy cycle.
  - perf_stalls counts FEED cycles with in_valid=0 plus DRAIN cycles with out_ready=0.
  - Both hold their value in IDLE.
  - Both reset to 0.
- Undefined: ports and counters absent; all other behaviour is identical.

Test Plan:
Parameters for all scenarios: SysDimension=4, featureLen=8, InitialLatency=5, in_valid=1, out_ready=1 unless stated.
1. Reset state -> with rst=0 held, every output is 0; after rst=1, busy=0 and no activity.
2. Single tile: start with num_tiles=1 ->
   - rd_en 8 cycles, addr 0..7;
   - feed_zero 11 cycles;
   - out_valid 4 cycles, rows 0..3, out_last on row 3;
   - done on the next cycle; busy high for 24 cycles total.
3. Two tiles with stalls: num_tiles=2; in_valid low at k=3 for 2 cycles; out_ready low on row 1 for 3 cycles ->
   - addresses 0..7 then 8..15, held during the stall;
   - array_enable low for exactly 2 cycles;
   - row 1 held 3 cycles;
   - out_last only on tile 1 row 3.
4. Zero tiles / ignored start: num_tiles=0 -> done on the 2nd cycle, no rd_en; a start pulse during FLUSH of a running job changes nothing.
5. Reset mid-DRAIN: assert rst=0 at row 2 -> immediate return to IDLE, outputs 0, no done pulse. A new start with num_tiles=1 then repeats scenario 2 exactly.
6. SYS_CTRL_PERF_EN defined, scenario 3 -> perf_stalls=5; perf_cycles equals the busy-cycle count.
